// File: rtl/vga_pkg.sv
// vga_pkg: shared video timing defaults, capture FSM encoding and write-FIFO entry width
package vga_pkg;
  localparam int DEF_H_BP       = 48;
  localparam int DEF_V_BP       = 33;
  localparam int DEF_H_ACTIVE   = 640;
  localparam int DEF_V_ACTIVE   = 480;
  localparam int DEF_FIFO_DEPTH = 4;
  localparam int ENTRY_W        = 27;
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ARM     = 2'd1;
  localparam logic [1:0] ST_CAPTURE = 2'd2;
  localparam logic [1:0] ST_DRAIN   = 2'd3;
endpackage

// File: rtl/pix_fifo.sv
// pix_fifo: first-word-fall-through write buffer; a push into a full FIFO is accepted only alongside a pop
module pix_fifo import vga_pkg::*; #(
  parameter int DEPTH = DEF_FIFO_DEPTH,
  parameter int W     = ENTRY_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clk_en,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic [W-1:0] i_data,
  output logic [W-1:0] o_data,
  output logic         o_full,
  output logic         o_empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wp;
  logic [AW-1:0] r_rp;
  logic [AW:0]   r_cnt;
  logic          w_push;
  logic          w_pop;
  // occupancy flags, qualified push/pop and the fall-through head word
  always_comb begin
    o_full  = r_cnt == (AW+1)'(DEPTH);
    o_empty = r_cnt == '0;
    w_pop   = i_pop & ~o_empty;
    w_push  = i_push & (~o_full | w_pop);
    o_data  = r_mem[r_rp];
  end
  // storage, pointers and occupancy count, frozen while clk_en is low
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else if (clk_en) begin
      if (w_push) begin
        r_mem[r_wp] <= i_data;
        r_wp        <= r_wp + 1'b1;
      end
      if (w_pop) r_rp <= r_rp + 1'b1;
      r_cnt <= r_cnt + {AW'(0), w_push} - {AW'(0), w_pop};
    end
  end
endmodule

// File: rtl/vga_capture.sv
// vga_capture: samples a sync-delimited pixel stream, clips it to a window and writes it to a frame buffer
module vga_capture import vga_pkg::*; #(
  parameter int H_BP       = DEF_H_BP,
  parameter int V_BP       = DEF_V_BP,
  parameter int H_ACTIVE   = DEF_H_ACTIVE,
  parameter int V_ACTIVE   = DEF_V_ACTIVE,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clk_en,
  input  logic        pix_en,
  input  logic        hsyncb,
  input  logic        vsyncb,
  input  logic [7:0]  rgb,
  input  logic [9:0]  Xoffset,
  input  logic [8:0]  Yoffset,
  input  logic [9:0]  imageWidth,
  input  logic [8:0]  imageHeight,
  input  logic        capture_req,
  input  logic        mem_ready,
  output logic [18:0] addr,
  output logic [7:0]  wdata,
  output logic        we,
  output logic        busy,
  output logic        frame_done,
  output logic        overflow
);
  localparam logic [10:0] C_HB  = 11'(H_BP);
  localparam logic [10:0] C_HE  = 11'(H_BP + H_ACTIVE);
  localparam logic [10:0] C_VB  = 11'(V_BP);
  localparam logic [10:0] C_VE  = 11'(V_BP + V_ACTIVE);
  localparam logic [10:0] C_MAX = 11'h7FF;
  logic                 r_hs;
  logic                 r_vs;
  logic [7:0]           r_rgb;
  logic                 r_new;
  logic [10:0]          r_hcnt;
  logic [10:0]          r_vcnt;
  logic [1:0]           r_state;
  logic [18:0]          r_addr_cnt;
  logic                 r_ovf;
  logic                 r_done;
  logic                 w_hs_rise;
  logic                 w_vs_rise;
  logic                 w_vs_fall;
  logic [10:0]          w_x;
  logic [10:0]          w_y;
  logic [10:0]          w_xe;
  logic [10:0]          w_ye;
  logic                 w_in_win;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_start;
  logic [1:0]           w_next;
  logic [ENTRY_W-1:0]   w_head;
  // sync edges, window test on the latest sample, FSM next state and output decode
  always_comb begin
    w_hs_rise  = pix_en & hsyncb & ~r_hs;
    w_vs_rise  = pix_en & vsyncb & ~r_vs;
    w_vs_fall  = pix_en & ~vsyncb & r_vs;
    w_x        = r_hcnt - C_HB;
    w_y        = r_vcnt - C_VB;
    w_xe       = {1'b0, Xoffset} + {1'b0, imageWidth};
    w_ye       = {2'b0, Yoffset} + {2'b0, imageHeight};
    w_in_win   = r_hcnt >= C_HB && r_hcnt < C_HE && r_vcnt >= C_VB && r_vcnt < C_VE &&
                 w_x >= {1'b0, Xoffset} && w_x < w_xe && w_y >= {2'b0, Yoffset} && w_y < w_ye;
    w_push     = r_new & w_in_win & (r_state == ST_CAPTURE);
    w_pop      = ~w_empty & mem_ready;
    w_start    = (r_state == ST_IDLE) & capture_req;
    w_next     = w_start ? ST_ARM :
                 (r_state == ST_ARM && w_vs_fall) ? ST_CAPTURE :
                 (r_state == ST_CAPTURE && w_vs_fall) ? ST_DRAIN :
                 (r_state == ST_DRAIN && w_empty) ? ST_IDLE : r_state;
    we         = ~w_empty;
    addr       = w_empty ? '0 : w_head[26:8];
    wdata      = w_empty ? '0 : w_head[7:0];
    busy       = r_state != ST_IDLE;
    frame_done = r_done;
    overflow   = r_ovf;
  end
  // register the stream on each pixel strobe; r_new marks a fresh sample for the push stage
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hs  <= 1'b1;
      r_vs  <= 1'b1;
      r_rgb <= '0;
      r_new <= 1'b0;
    end else if (clk_en) begin
      r_new <= pix_en;
      if (pix_en) begin
        r_hs  <= hsyncb;
        r_vs  <= vsyncb;
        r_rgb <= rgb;
      end
    end
  end
  // saturating position counters restarted by the sync rising edges
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hcnt <= '0;
      r_vcnt <= '0;
    end else if (clk_en & pix_en) begin
      r_hcnt <= w_hs_rise ? '0 : (r_hcnt == C_MAX) ? r_hcnt : r_hcnt + 1'b1;
      r_vcnt <= w_vs_rise ? '0 : (w_hs_rise && r_vcnt != C_MAX) ? r_vcnt + 1'b1 : r_vcnt;
    end
  end
  // capture FSM, window address counter (advances even for dropped pixels) and sticky overflow
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_addr_cnt <= '0;
      r_ovf      <= 1'b0;
    end else if (clk_en) begin
      r_state <= w_next;
      if (w_start) begin
        r_addr_cnt <= '0;
        r_ovf      <= 1'b0;
      end else begin
        if (w_push) r_addr_cnt <= r_addr_cnt + 1'b1;
        if (w_push & w_full & ~w_pop) r_ovf <= 1'b1;
      end
    end
  end
  // single-clock completion pulse on the DRAIN to IDLE transition
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_done <= 1'b0;
    else      r_done <= clk_en & (r_state == ST_DRAIN) & w_empty;
  end
  pix_fifo #(.DEPTH(FIFO_DEPTH), .W(ENTRY_W)) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .clk_en (clk_en),
    .i_push (w_push),
    .i_pop  (w_pop),
    .i_data ({r_addr_cnt, r_rgb}),
    .o_data (w_head),
    .o_full (w_full),
    .o_empty(w_empty)
  );
endmodule

// File: tb/tb_vga_capture.sv
// tb_vga_capture: directed frames on a shrunken 16x8 raster with hand-computed write expectations
module tb_vga_capture;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clk_en = 1'b1;
  logic        pix_en = 1'b0;
  logic        hsyncb = 1'b1;
  logic        vsyncb = 1'b1;
  logic [7:0]  rgb = '0;
  logic [9:0]  Xoffset = '0;
  logic [8:0]  Yoffset = '0;
  logic [9:0]  imageWidth = '0;
  logic [8:0]  imageHeight = '0;
  logic        capture_req = 1'b0;
  logic        mem_ready = 1'b1;
  logic [18:0] addr;
  logic [7:0]  wdata;
  logic        we;
  logic        busy;
  logic        frame_done;
  logic        overflow;
  int          n_vec = 0;
  int          n_bad = 0;
  int          done_cnt = 0;
  int          d0 = 0;
  int          bp_y = -1;
  logic [18:0] wa[$];
  logic [7:0]  wd[$];
  logic [7:0]  win_exp [8] = '{8'd90, 8'd91, 8'd92, 8'd93, 8'd106, 8'd107, 8'd108, 8'd109};

  vga_capture #(.H_BP(4), .V_BP(2), .H_ACTIVE(16), .V_ACTIVE(8), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .pix_en(pix_en), .hsyncb(hsyncb), .vsyncb(vsyncb),
    .rgb(rgb), .Xoffset(Xoffset), .Yoffset(Yoffset), .imageWidth(imageWidth),
    .imageHeight(imageHeight), .capture_req(capture_req), .mem_ready(mem_ready),
    .addr(addr), .wdata(wdata), .we(we), .busy(busy), .frame_done(frame_done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // record every accepted write and every completion pulse, away from the active edge
  always @(negedge clk) begin
    if (rst && clk_en && we && mem_ready) begin
      wa.push_back(addr);
      wd.push_back(wdata);
    end
    if (frame_done) done_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] at_a(input int i);
    return (i < wa.size()) ? 32'(wa[i]) : 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] at_d(input int i);
    return (i < wd.size()) ? 32'(wd[i]) : 32'hFFFF_FFFF;
  endfunction

  task automatic strobe(input logic hs, input logic vs, input logic [7:0] px);
    hsyncb = hs;
    vsyncb = vs;
    rgb    = px;
    pix_en = 1'b1;
    @(posedge clk); #1;
    pix_en = 1'b0;
    @(posedge clk); #1;
  endtask

  // 3 sync + 4 back porch + 16 active + 2 front porch strobes; pixel value is y*16+x
  task automatic line(input logic vs, input int y);
    int   x;
    logic act;
    for (int i = 0; i < 25; i++) begin
      x   = i - 7;
      act = y >= 0 && x >= 0 && x < 16;
      if (act && x == 0 && y == bp_y)
        fork
          begin
            mem_ready = 1'b0;
            repeat (12) @(posedge clk);
            #1 mem_ready = 1'b1;
          end
        join_none
      strobe(i >= 3, vs, act ? 8'(y * 16 + x) : 8'hFF);
    end
  endtask

  task automatic body();
    line(1'b0, -1);
    for (int j = 0; j < 10; j++) line(1'b1, (j >= 1 && j <= 8) ? j - 1 : -1);
  endtask

  task automatic frame();
    line(1'b0, -1);
    body();
  endtask

  task automatic setup(input int xo, input int yo, input int w, input int h);
    Xoffset     = 10'(xo);
    Yoffset     = 9'(yo);
    imageWidth  = 10'(w);
    imageHeight = 9'(h);
    wa.delete();
    wd.delete();
    d0 = done_cnt;
    capture_req = 1'b1;
    @(posedge clk); #1;
    capture_req = 1'b0;
  endtask

  task automatic capture(input int xo, input int yo, input int w, input int h);
    setup(xo, yo, w, h);
    frame();
    frame();
  endtask

  initial begin
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_we", we, 0);
    chk("rst_busy", busy, 0);
    chk("rst_addr", addr, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_ovf", overflow, 0);
    rst = 1'b1;
    frame();

    capture(0, 0, 16, 8);
    chk("full_count", wa.size(), 128);
    chk("full_a0", at_a(0), 0);
    chk("full_d0", at_d(0), 0);
    chk("full_d16", at_d(16), 16);
    chk("full_alast", at_a(127), 127);
    chk("full_dlast", at_d(127), 127);
    chk("full_done", done_cnt - d0, 1);
    chk("full_busy", busy, 0);

    capture(10, 5, 4, 2);
    chk("win_count", wa.size(), 8);
    for (int i = 0; i < 8; i++) begin
      chk("win_addr", at_a(i), 32'(i));
      chk("win_data", at_d(i), 32'(win_exp[i]));
    end
    chk("win_done", done_cnt - d0, 1);

    capture(14, 0, 10, 8);
    chk("clip_count", wa.size(), 16);
    chk("clip_d0", at_d(0), 14);
    chk("clip_d1", at_d(1), 15);
    chk("clip_d2", at_d(2), 30);
    chk("clip_a15", at_a(15), 15);
    chk("clip_d15", at_d(15), 127);

    bp_y = 3;
    capture(0, 3, 16, 1);
    bp_y = -1;
    chk("bp_count", wa.size(), 14);
    chk("bp_a3", at_a(3), 3);
    chk("bp_a4", at_a(4), 6);
    chk("bp_d4", at_d(4), 54);
    chk("bp_a13", at_a(13), 15);
    chk("bp_d13", at_d(13), 63);
    chk("bp_ovf", overflow, 1);

    setup(0, 0, 0, 8);
    chk("w0_ovf_clr", overflow, 0);
    line(1'b0, -1);
    chk("w0_busy_mid", busy, 1);
    body();
    frame();
    chk("w0_count", wa.size(), 0);
    chk("w0_done", done_cnt - d0, 1);
    chk("w0_busy_end", busy, 0);

    setup(0, 0, 16, 8);
    line(1'b0, -1);
    line(1'b0, -1);
    line(1'b1, -1);
    line(1'b1, 0);
    line(1'b1, 1);
    chk("mid_busy", busy, 1);
    rst = 1'b0;
    #2;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_we", we, 0);
    chk("mid_rst_addr", addr, 0);
    chk("mid_rst_wdata", wdata, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    d0 = done_cnt;
    frame();
    chk("mid_no_done", done_cnt - d0, 0);
    capture(10, 5, 4, 2);
    chk("restart_count", wa.size(), 8);
    chk("restart_a0", at_a(0), 0);
    chk("restart_d0", at_d(0), 90);
    chk("restart_done", done_cnt - d0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/vga_capture.md
Name: vga_capture

Overview:
- Video-input counterpart of the VGA display path: samples an incoming 640x480 pixel stream (hsyncb/vsyncb/8-bit rgb) instead of generating it.
- Measures the horizontal and vertical position of each pixel from the sync edges.
- Clips the stream to a programmable window (offset plus size).
- Writes the window's pixels into the frame buffer at linear 19-bit addresses, through a small FIFO with a ready handshake.

Parameters:
- H_BP, 48, pixel strobes from hsyncb rising edge to first active pixel
- V_BP, 33, lines from vsyncb rising edge to first active line
- H_ACTIVE, 640, active pixels per line
- V_ACTIVE, 480, active lines per frame
- FIFO_DEPTH, 4, write-buffer entries (power of 2)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- clk_en  in  1  global clock enable; all state frozen when 0
- pix_en  in  1  pixel strobe (25 MHz-rate enable); sample inputs when clk_en & pix_en
- hsyncb  in  1  horizontal sync, active low, synchronous to clk
- vsyncb  in  1  vertical sync, active low, synchronous to clk
- rgb  in  8  incoming pixel
- Xoffset  in  10  window left edge (active pixels)
- Yoffset  in  9  window top edge (active lines)
- imageWidth  in  10  window width
- imageHeight  in  9  window height
- capture_req  in  1  one-frame capture request (level sampled in IDLE)
- mem_ready  in  1  frame buffer accepts write this cycle
- addr  out  19  write address
- wdata  out  8  write pixel
- we  out  1  write valid
- busy  out  1  high in any state other than IDLE
- frame_done  out  1  one-cycle pulse when a capture completes
- overflow  out  1  sticky: pixel dropped because the FIFO was full

Behaviour:

Reset:
- rst=0 asynchronously clears addr, wdata, we, busy, frame_done, overflow, all counters and the FIFO, and sets the FSM to IDLE.
- Reset mid-frame abandons the frame; no frame_done is issued.

Sampling:
- On each strobe (clk_en & pix_en), register hsyncb, vsyncb and rgb.
- Edges are detected against the previous strobe's registered values.

Counters (11-bit internally):
- hcnt: cleared on hsyncb rising edge; increments per strobe; saturates at 2047.
- vcnt: cleared on vsyncb rising edge; increments on each hsyncb rising edge; saturates.
- Active x = hcnt - H_BP, valid when H_BP <= hcnt < H_BP+H_ACTIVE. Active y uses V_BP and V_ACTIVE the same way.

Window qualification:
- A pixel is in the window iff Xoffset <= x < Xoffset+imageWidth and Yoffset <= y < Yoffset+imageHeight, with the pixel also in the active region.
- Sums are computed 11 bits wide; the window is clipped to the active area.
- imageWidth=0 or imageHeight=0 means no writes; the frame still completes.

FSM:
- IDLE: capture_req=1 -> ARM; clears overflow and the address counter.
- ARM: vsyncb falling edge -> CAPTURE.
- CAPTURE: each in-window strobe pushes {addr_cnt, rgb} into the FIFO, then addr_cnt++. The next vsyncb falling edge -> DRAIN.
- DRAIN: when the FIFO is empty -> IDLE, with frame_done=1 for exactly one clk.
- capture_req is ignored outside IDLE.

Latency and handshake:
- FIFO push happens at the clk edge after the sampling edge. The FIFO is first-word-fall-through.
- we goes high the cycle after the push if the FIFO was empty, i.e. 2 clk edges after sampling.
- Transfer occurs when we & mem_ready & clk_en; the FIFO pops on the same edge.
- addr and wdata are stable while we=1 and mem_ready=0.
- Simultaneous push and pop when full is allowed (occupancy unchanged, no drop).

Overflow:
- A push while full (and no pop) drops the pixel and sets overflow.
- addr_cnt still increments, so later pixels keep their correct addresses.

Address:
- Linear address from 0, in raster order over the window.
- Maximum is 307199; no wrap within legal settings.

Decomposition:
- Shared package vga_pkg: H_ACTIVE/V_ACTIVE/H_BP/V_BP defaults, FSM state encoding (IDLE, ARM, CAPTURE, DRAIN), and the FIFO entry width (27 bits).
- Sub-module pix_fifo: synchronous FWFT FIFO with parameterised depth, plus full/empty, push/pop and clk_en inputs.

Test Plan:
- Reset mid-CAPTURE: rst low for 3 clk -> all outputs 0, busy=0; no frame_done; the next capture_req restarts at addr 0.
- Full-frame capture with offsets 0/0, size 640x480, mem_ready=1 -> 307200 writes; first write addr 0 carries the first active pixel; last write addr 307199; one frame_done pulse after the second vsyncb fall.
- Window Xoffset=10, Yoffset=5, 4x2 -> exactly 8 writes, addr 0..7. wdata equals pixels x=10..13 on y=5 and y=6.
- Window Xoffset=638, width 10 -> only x=638,639 are written per line (clipping).
- Backpressure: mem_ready=0 for 12 clk during an in-window run -> no further pushes are accepted once the FIFO is full; overflow=1. The addresses of later pixels skip the dropped ones.
- imageWidth=0 with capture_req -> zero writes; busy high for one frame; frame_done pulses once.
